// File: rtl/pio_event_sequencer_if.sv
// Bus and event-stream signals of the PIO event sequencer: Avalon-MM master
// toward the edge-capture PIO plus the first-word-fall-through event output.
interface pio_event_sequencer_if #(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_edges;
  logic [DATA_W-1:0] evt_level;
  logic [CNT_W-1:0]  evt_count;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata,
    output evt_valid, evt_edges, evt_level, evt_count,
    input  evt_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata,
    input  evt_valid, evt_edges, evt_level, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/pio_event_sequencer.sv
// Services edge-capture PIO interrupts: reads and clears the capture register,
// samples the input level and queues {edges, level} events in a small FIFO.
module pio_event_sequencer #(
  parameter int                DATA_W     = 18,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IRQ_MASK   = 18'h3FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pio_irq,
  output logic overflow,
  input  logic overflow_clr,
  pio_event_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_LVL, LVL_WAIT, PUSH
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] lvl_q;

  logic [DATA_W-1:0] mem_edges [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_level [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic pop, full, has_event, push, drop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cap_q <= '0;
      lvl_q <= '0;
    end else begin
      unique case (state)
        INIT:     state <= IDLE;
        IDLE:     if (enable && pio_irq) state <= RD_CAP;
        RD_CAP:   state <= CAP_WAIT;
        CAP_WAIT: begin
          cap_q <= bus.avm_readdata[DATA_W-1:0];
          state <= CLR;
        end
        CLR:      state <= RD_LVL;
        RD_LVL:   state <= LVL_WAIT;
        LVL_WAIT: begin
          lvl_q <= bus.avm_readdata[DATA_W-1:0];
          state <= PUSH;
        end
        PUSH:     state <= IDLE;
        default:  state <= INIT;
      endcase
    end
  end

  // Bus strobes are a pure decode of the state register, held idle during reset
  // so the mask write appears in the first cycle after reset is released.
  // NOTE: every output of this always_comb gets a default first, so no latch
  // can be inferred for states that leave a field untouched.
  always_comb begin
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_address    = 2'd0;
    bus.avm_writedata  = 32'd0;
    if (!reset) begin
      unique case (state)
        INIT: begin
          bus.avm_chipselect = 1'b1;
          bus.avm_write_n    = 1'b0;
          bus.avm_address    = 2'd2;
          bus.avm_writedata  = 32'(IRQ_MASK);
        end
        RD_CAP: begin
          bus.avm_chipselect = 1'b1;
          bus.avm_address    = 2'd3;
        end
        CLR: begin
          bus.avm_chipselect = 1'b1;
          bus.avm_write_n    = 1'b0;
          bus.avm_address    = 2'd3;
        end
        RD_LVL: bus.avm_chipselect = 1'b1;
        default: ;
      endcase
    end
  end

  assign pop       = bus.evt_valid && bus.evt_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign has_event = (state == PUSH) && (cap_q != '0);
  assign push      = has_event && (!full || pop);
  assign drop      = has_event && !push;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; the empty FIFO masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_edges[wr_ptr] <= cap_q;
      mem_level[wr_ptr] <= lvl_q;
    end
  end

  assign bus.evt_valid = (count != '0);
  assign bus.evt_count = count;
  assign bus.evt_edges = bus.evt_valid ? mem_edges[rd_ptr] : '0;
  assign bus.evt_level = bus.evt_valid ? mem_level[rd_ptr] : '0;

  if (DATA_W < 32) begin : g_readdata_upper
    logic unused_readdata;
    assign unused_readdata = ^bus.avm_readdata[31:DATA_W];
  end
endmodule

// File: tb/tb_pio_event_sequencer.sv
// Directed bench for pio_event_sequencer with a behavioural edge-capture PIO.
module tb_pio_event_sequencer;
  logic clk = 1'b0;
  logic reset, enable, pio_irq, overflow, overflow_clr;

  int n_checks = 0;
  int n_errors = 0;
  int cs_cnt   = 0;

  pio_event_sequencer_if #(.DATA_W(18), .FIFO_DEPTH(4)) bus ();

  pio_event_sequencer #(.DATA_W(18), .FIFO_DEPTH(4), .IRQ_MASK(18'h3FFFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pio_irq      (pio_irq),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Edge-capture PIO: registered reads, latency 1; write to 3 clears capture.
  logic [17:0] pio_data = '0;
  logic [17:0] pio_cap  = '0;
  logic [17:0] pio_mask = '0;
  logic [17:0] edges_in = '0;

  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write_n) begin
      case (bus.avm_address)
        2'd0:    bus.avm_readdata <= {14'h1ABC, pio_data};
        2'd3:    bus.avm_readdata <= {14'h1ABC, pio_cap};
        default: bus.avm_readdata <= 32'h0;
      endcase
    end else begin
      bus.avm_readdata <= 32'h0;
    end
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
      pio_mask <= bus.avm_writedata[17:0];
    pio_cap <= ((bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
                ? 18'h0 : pio_cap) | edges_in;
  end

  always @(negedge clk) if (bus.avm_chipselect) cs_cnt = cs_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {chipselect, write_n, address}: idle=4'b0100, rd3=4'b1111, wr3=4'b1011,
  // rd0=4'b1100, wr2=4'b1010
  function automatic logic [3:0] bus_word();
    return {bus.avm_chipselect, bus.avm_write_n, bus.avm_address};
  endfunction

  // Load PIO, raise irq for one cycle (enable dropped with it), run to cycle N+7.
  task automatic run_event(input logic [17:0] edges, input logic [17:0] level,
                           input logic en, input logic pop_at_push, output int cs_seen);
    int start;
    @(negedge clk); pio_data = level; edges_in = edges;
    @(negedge clk); edges_in = '0; enable = en; pio_irq = 1'b1; start = cs_cnt;
    @(posedge clk); @(negedge clk); pio_irq = 1'b0; enable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); if (pop_at_push) bus.evt_ready = 1'b1;
    @(posedge clk); @(negedge clk); bus.evt_ready = 1'b0;
    cs_seen = cs_cnt - start;
  endtask

  task automatic pop_one();
    bus.evt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  typedef struct {
    logic [17:0] edges;
    logic [17:0] level;
    logic        en;
    logic        exp_valid;
    int          exp_cs;
  } vec_t;

  typedef struct {
    logic [17:0] edges;
    logic [17:0] level;
  } evt_t;

  vec_t vecs[6];
  evt_t ov[7];
  evt_t drain_exp[4];
  logic [3:0] seq_exp[5];

  initial begin
    int cs_seen;

    vecs[0] = '{18'h00001, 18'h12345, 1'b1, 1'b1, 3};
    vecs[1] = '{18'h20000, 18'h00000, 1'b1, 1'b1, 3};
    vecs[2] = '{18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 3};
    vecs[3] = '{18'h00000, 18'h0AAAA, 1'b1, 1'b0, 3};
    vecs[4] = '{18'h00000, 18'h15555, 1'b0, 1'b0, 0};
    vecs[5] = '{18'h0F0F0, 18'h2AAAA, 1'b1, 1'b1, 3};

    ov[0] = '{18'h00011, 18'h00101};
    ov[1] = '{18'h00022, 18'h00202};
    ov[2] = '{18'h00044, 18'h00404};
    ov[3] = '{18'h00088, 18'h00808};
    ov[4] = '{18'h00100, 18'h01001};
    ov[5] = '{18'h00200, 18'h02002};
    ov[6] = '{18'h00400, 18'h04004};
    drain_exp[0] = ov[1];
    drain_exp[1] = ov[2];
    drain_exp[2] = ov[3];
    drain_exp[3] = ov[5];

    seq_exp[0] = 4'b1111;
    seq_exp[1] = 4'b0100;
    seq_exp[2] = 4'b1011;
    seq_exp[3] = 4'b1100;
    seq_exp[4] = 4'b0100;

    reset = 1'b1; enable = 1'b0; pio_irq = 1'b0; overflow_clr = 1'b0;
    bus.evt_ready = 1'b0;

    // Reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_bus", 32'(bus_word()), 32'h4);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    check("rst_valid", 32'(bus.evt_valid), 32'h0);
    check("rst_count", 32'(bus.evt_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_edges", 32'(bus.evt_edges), 32'h0);
    check("rst_level", 32'(bus.evt_level), 32'h0);
    reset = 1'b0; #1;
    check("init_bus", 32'(bus_word()), 32'hA);
    check("init_wdata", bus.avm_writedata, 32'h3FFFF);
    @(posedge clk); @(negedge clk);
    check("after_init_bus", 32'(bus_word()), 32'h4);
    check("pio_mask", 32'(pio_mask), 32'h3FFFF);

    // Single event: bus sequence and 7-cycle latency
    @(negedge clk); pio_data = 18'h3FFFB; edges_in = 18'h00004;
    @(negedge clk); edges_in = '0; enable = 1'b1; pio_irq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) begin pio_irq = 1'b0; enable = 1'b0; end
      check($sformatf("seq_bus_n%0d", k + 1), 32'(bus_word()), 32'(seq_exp[k]));
      if (k == 2) check("seq_clr_wdata", bus.avm_writedata, 32'h0);
    end
    @(posedge clk); @(negedge clk);
    check("lat_n6_valid", 32'(bus.evt_valid), 32'h0);
    @(posedge clk); @(negedge clk);
    check("lat_n7_valid", 32'(bus.evt_valid), 32'h1);
    check("single_edges", 32'(bus.evt_edges), 32'h00004);
    check("single_level", 32'(bus.evt_level), 32'h3FFFB);
    check("single_count", 32'(bus.evt_count), 32'h1);
    pop_one();
    check("single_pop_count", 32'(bus.evt_count), 32'h0);
    check("single_pop_valid", 32'(bus.evt_valid), 32'h0);

    // Table-driven events, including spurious irq and enable=0
    for (int i = 0; i < 6; i++) begin
      run_event(vecs[i].edges, vecs[i].level, vecs[i].en, 1'b0, cs_seen);
      check($sformatf("vec%0d_cs", i), 32'(cs_seen), 32'(vecs[i].exp_cs));
      check($sformatf("vec%0d_valid", i), 32'(bus.evt_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 32'(bus.evt_count), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_edges", i), 32'(bus.evt_edges),
            vecs[i].exp_valid ? 32'(vecs[i].edges) : 32'h0);
      check($sformatf("vec%0d_level", i), 32'(bus.evt_level),
            vecs[i].exp_valid ? 32'(vecs[i].level) : 32'h0);
      if (vecs[i].exp_valid) pop_one();
    end

    // Overflow: five events into a four-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      run_event(ov[i].edges, ov[i].level, 1'b1, 1'b0, cs_seen);
      if (i == 3) check("ov_before_drop", 32'(overflow), 32'h0);
    end
    check("ov_count", 32'(bus.evt_count), 32'h4);
    check("ov_flag", 32'(overflow), 32'h1);
    check("ov_head_edges", 32'(bus.evt_edges), 32'(ov[0].edges));
    check("ov_head_level", 32'(bus.evt_level), 32'(ov[0].level));
    overflow_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    overflow_clr = 1'b0;
    check("ov_cleared", 32'(overflow), 32'h0);

    // Full FIFO with a pop in the PUSH cycle accepts the new event
    run_event(ov[5].edges, ov[5].level, 1'b1, 1'b1, cs_seen);
    check("fwp_count", 32'(bus.evt_count), 32'h4);
    check("fwp_overflow", 32'(overflow), 32'h0);
    check("fwp_head", 32'(bus.evt_edges), 32'(ov[1].edges));

    // Drop coinciding with overflow_clr: set wins
    overflow_clr = 1'b1;
    run_event(ov[6].edges, ov[6].level, 1'b1, 1'b0, cs_seen);
    check("set_wins", 32'(overflow), 32'h1);
    @(posedge clk); @(negedge clk);
    overflow_clr = 1'b0;
    check("set_wins_then_clr", 32'(overflow), 32'h0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_edges", i), 32'(bus.evt_edges), 32'(drain_exp[i].edges));
      check($sformatf("drain%0d_level", i), 32'(bus.evt_level), 32'(drain_exp[i].level));
      pop_one();
    end
    check("drain_count", 32'(bus.evt_count), 32'h0);
    pop_one();
    check("ready_when_empty", 32'(bus.evt_count), 32'h0);

    // Reset asserted in RD_LVL abandons the sequence
    @(negedge clk); pio_data = 18'h00777; edges_in = 18'h00008;
    @(negedge clk); edges_in = '0; enable = 1'b1; pio_irq = 1'b1;
    @(posedge clk); @(negedge clk); pio_irq = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rdlvl_bus", 32'(bus_word()), 32'hC);
    reset = 1'b1; #1;
    check("rst_mid_bus", 32'(bus_word()), 32'h4);
    @(posedge clk); @(negedge clk);
    reset = 1'b0; #1;
    check("rst_mid_init", 32'(bus_word()), 32'hA);
    check("rst_mid_count", 32'(bus.evt_count), 32'h0);
    @(posedge clk); @(negedge clk);
    check("rst_mid_idle", 32'(bus_word()), 32'h4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_event", 32'(bus.evt_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pio_event_sequencer.md
PIO_EVENT_SEQUENCER -- requirements
Module: pio_event_sequencer

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 18, PIO input width; FIFO_DEPTH, default 4, event FIFO entries (power of 2, >=2); IRQ_MASK, default 18'h3FFFF, value written to the PIO interrupt-mask register.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits starting a new service sequence
- pio_irq  in  1  interrupt from the edge-capture PIO
- avm_address  out  2  PIO register select
- avm_chipselect  out  1  PIO access strobe
- avm_write_n  out  1  active-low write
- avm_writedata  out  32  write data
- avm_readdata  in  32  PIO registered read data, fixed latency 1
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_edges  out  DATA_W  head: captured falling-edge bits
- evt_level  out  DATA_W  head: input level sampled after clear
- evt_count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky: event dropped
- overflow_clr  in  1  clears overflow

Function
REQ-003 PIO register map SHALL be: 0 = data (read), 2 = irq mask (write), 3 = edge capture (read; any write clears all bits).
REQ-004 Bus idle SHALL be: chipselect=0, write_n=1, address=0, writedata=0.
REQ-005 The FSM SHALL have the states INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_LVL, LVL_WAIT and PUSH, each lasting exactly one cycle except IDLE.
REQ-006 INIT: chipselect=1, write_n=0, address=2, writedata=zero-extended IRQ_MASK; next state IDLE.
REQ-007 IDLE: bus idle; go to RD_CAP when enable=1 and pio_irq=1, else stay.
REQ-008 RD_CAP: chipselect=1, write_n=1, address=3; next CAP_WAIT.
REQ-009 CAP_WAIT: bus idle; cap_q <= avm_readdata[DATA_W-1:0]; next CLR.
REQ-010 CLR: chipselect=1, write_n=0, address=3, writedata=0; next RD_LVL.
REQ-011 RD_LVL: chipselect=1, write_n=1, address=0; next LVL_WAIT.
REQ-012 LVL_WAIT: bus idle; lvl_q <= avm_readdata[DATA_W-1:0]; next PUSH.
REQ-013 PUSH: bus idle; next IDLE. The action SHALL depend on the FIFO and cap_q:
- cap_q==0: no push; overflow unchanged (spurious irq).
- FIFO accepts: push {cap_q, lvl_q}.
- FIFO does not accept: drop the entry and set overflow=1.
REQ-014 The FIFO SHALL accept a push when not full, or when full with a pop in the same cycle.
REQ-015 Irq-to-evt_valid latency SHALL be 7 cycles: irq sampled in IDLE at cycle N, PUSH at N+6, evt_valid=1 at N+7 when the FIFO was empty.
REQ-016 The FIFO SHALL be first-word-fall-through: evt_valid = (evt_count!=0), with evt_edges/evt_level showing the head.
REQ-017 A pop SHALL occur when evt_valid && evt_ready; with evt_valid=0, evt_ready SHALL have no effect.
REQ-018 evt_count SHALL be incremented by push only, decremented by pop only, unchanged by simultaneous push and pop; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 evt_edges/evt_level SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-020 overflow_clr SHALL clear overflow; when set and clear coincide, set SHALL win.
REQ-021 Deasserting enable mid-sequence SHALL NOT abort it; the sequence SHALL complete through PUSH.
REQ-022 Edges arriving between the RD_CAP sample and the CLR write are lost; this is an accepted, documented window of 2 cycles.

Reset
REQ-023 While reset=1 the block SHALL force: bus idle, FSM=INIT, FIFO empty (evt_valid=0, evt_count=0), overflow=0, cap_q=lvl_q=0, evt_edges/evt_level=0.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence and discard any partial event; the first cycle after reset deassertion SHALL be INIT.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset release: cycle 1 shows chipselect=1, write_n=0, address=2, writedata=0x3FFFF; the next cycle shows bus idle.
- Single event: PIO edge_capture=0x00004, data=0x3FFFB, irq pulse with enable=1 -> bus sequence rd3, idle, wr3 (data 0), rd0, idle; evt_valid at +7 with evt_edges=0x00004, evt_level=0x3FFFB.
- Overflow: evt_ready=0, 5 events with DEPTH=4 -> evt_count=4, overflow=1, head = first event; overflow_clr -> overflow=0.
- Full-with-pop: FIFO full, evt_ready=1 in the PUSH cycle -> push accepted, evt_count stays 4, overflow stays 0.
- Spurious irq: capture reads 0 -> no push, evt_count unchanged; enable=0 with irq=1 -> FSM stays IDLE, no bus access.
- Reset at RD_LVL: the next cycle after release is INIT; evt_count=0; no event emitted.
